// File: rtl/btb_update_arbiter.sv
// Two-port BTB update arbiter: round-robin accept, coalescing FIFO, flush sequencing.
// Define BTB_UPD_STATS_EN to add saturating coalesce/drop/flush statistics outputs.
package btb_update_arbiter_pkg;
  localparam int unsigned VLEN = 32;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic [VLEN-1:0] target_address;
  } btb_update_t;
endpackage

module btb_update_arbiter
  import btb_update_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  debug_mode_i,
  input  logic [1:0]            req_valid_i,
  output logic [1:0]            req_ready_o,
  input  logic [1:0][VLEN-1:0]  req_pc_i,
  input  logic [1:0][VLEN-1:0]  req_target_i,
  output btb_update_t           btb_update_o,
  output logic                  btb_flush_o,
  output logic                  busy_o
`ifdef BTB_UPD_STATS_EN
  ,
  output logic [15:0]           stat_coalesced_o,
  output logic [15:0]           stat_dropped_o,
  output logic [15:0]           stat_flushed_o
`endif
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = $clog2(DEPTH + 1);
  localparam int unsigned CNTW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNTW-1:0]   r_cnt, w_cnt_nxt;
  logic [VLEN-1:0]   r_pc  [DEPTH];
  logic [VLEN-1:0]   r_tgt [DEPTH];
  logic [AW-1:0]     r_head, r_tail;
  logic [CW-1:0]     r_count;
  logic              r_rr;
  logic              r_rst_done;
  logic              r_flush;

  logic              w_both, w_grant, w_can_accept, w_hs, w_push, w_pop;
  logic              w_coalesce, w_enq;
  logic [AW-1:0]     w_tail_idx;
  logic [VLEN-1:0]   w_win_pc, w_win_tgt;

  assign w_both       = req_valid_i[0] & req_valid_i[1];
  assign w_grant      = w_both ? r_rr : req_valid_i[1];
  assign w_can_accept = r_rst_done && (r_state == ST_RUN) && !flush_i && (r_count < CW'(DEPTH));
  assign req_ready_o  = {w_can_accept & w_grant, w_can_accept & ~w_grant};
  assign w_hs         = w_can_accept && req_valid_i[w_grant];
  // Requests granted in debug mode are handshaken but never reach the FIFO.
  assign w_push       = w_hs && !debug_mode_i;
  assign w_pop        = (r_count != CW'(0)) && (r_state == ST_RUN) && !debug_mode_i && !flush_i;
  assign w_win_pc     = req_pc_i[w_grant];
  assign w_win_tgt    = req_target_i[w_grant];
  assign w_tail_idx   = r_tail - AW'(1);
  assign w_coalesce   = w_push && (r_count != CW'(0)) && (w_win_pc == r_pc[w_tail_idx])
                        && !(w_pop && (r_count == CW'(1)));
  assign w_enq        = w_push && !w_coalesce;
  assign busy_o       = (r_count != CW'(0)) || (r_state == ST_FLUSH);
  assign btb_flush_o  = r_flush;

  // Flush state register and hold-off counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: any flush_i (re)loads the hold-off window.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_RUN: begin
        if (flush_i) begin
          w_state_nxt = ST_FLUSH;
          w_cnt_nxt   = CNTW'(FLUSH_CYCLES);
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (flush_i) begin
          w_cnt_nxt = CNTW'(FLUSH_CYCLES);
        end else if (r_cnt == CNTW'(1)) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNTW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // FIFO storage, pointers and occupancy; flush_i empties it without issuing.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]  <= '0;
        r_tgt[i] <= '0;
      end
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) begin
        r_head <= r_head + AW'(1);
      end
      if (w_enq) begin
        r_pc[r_tail]  <= w_win_pc;
        r_tgt[r_tail] <= w_win_tgt;
        r_tail        <= r_tail + AW'(1);
      end
      if (w_coalesce) begin
        r_tgt[w_tail_idx] <= w_win_tgt;
      end
      r_count <= r_count + CW'(w_enq) - CW'(w_pop);
    end
  end

  // Round-robin pointer, post-reset ready enable and flush pulse register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr       <= 1'b0;
      r_rst_done <= 1'b0;
      r_flush    <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
      r_flush    <= flush_i;
      if (w_hs && w_both) begin
        r_rr <= ~r_rr;
      end
    end
  end

  // Update bus is all-zero whenever no entry is issued.
  always_comb begin
    btb_update_o = '0;
    if (w_pop) begin
      btb_update_o.valid          = 1'b1;
      btb_update_o.pc             = r_pc[r_head];
      btb_update_o.target_address = r_tgt[r_head];
    end else begin
      btb_update_o = '0;
    end
  end

`ifdef BTB_UPD_STATS_EN
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [CW-1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Statistics survive flushes; only reset clears them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_coalesced_o <= 16'h0000;
      stat_dropped_o   <= 16'h0000;
      stat_flushed_o   <= 16'h0000;
    end else begin
      stat_coalesced_o <= sat_add(stat_coalesced_o, CW'(w_coalesce));
      stat_dropped_o   <= sat_add(stat_dropped_o, CW'(w_hs && debug_mode_i));
      stat_flushed_o   <= sat_add(stat_flushed_o, flush_i ? r_count : CW'(0));
    end
  end
`endif

endmodule

// File: tb/tb_btb_update_arbiter.sv
// Self-checking bench for btb_update_arbiter: directed scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_btb_update_arbiter;
  import btb_update_arbiter_pkg::*;

  localparam int DEPTH        = 4;
  localparam int FLUSH_CYCLES = 2;

  logic                 clk, rst_n, flush, dbg;
  logic [1:0]           valid, ready;
  logic [1:0][VLEN-1:0] pc, tgt;
  btb_update_t          upd;
  logic                 bflush, busy;
`ifdef BTB_UPD_STATS_EN
  logic [15:0]          st_coal, st_drop, st_fl;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  btb_update_arbiter #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .debug_mode_i (dbg),
    .req_valid_i  (valid),
    .req_ready_o  (ready),
    .req_pc_i     (pc),
    .req_target_i (tgt),
    .btb_update_o (upd),
    .btb_flush_o  (bflush),
    .busy_o       (busy)
`ifdef BTB_UPD_STATS_EN
    ,
    .stat_coalesced_o (st_coal),
    .stat_dropped_o   (st_drop),
    .stat_flushed_o   (st_fl)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; dbg = 1'b0; valid = 2'b00; pc = '0; tgt = '0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; dbg = 1'b0; valid = 2'b11; pc = '0; tgt = '0;
    @(posedge clk);
    #3;
    n_checks++; if (upd !== '0) begin n_fail++; $display("FAIL reset_upd: got %h exp 0", upd); end
    n_checks++; if (bflush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b exp 0", bflush); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_checks++; if (ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b exp 00", ready); end
    valid = 2'b00;
    #2 rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_single_push();
    btb_update_t e;
    valid = 2'b01; pc[0] = 32'h0000_1000; tgt[0] = 32'h0000_2000;
    #1;
    n_checks++; if (ready !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b exp 01", ready); end
    n_checks++; if (upd !== '0) begin n_fail++; $display("FAIL single_idle: got %h exp 0", upd); end
    next_cycle();
    valid = 2'b00;
    #1;
    e = '{valid: 1'b1, pc: 32'h0000_1000, target_address: 32'h0000_2000};
    n_checks++; if (upd !== e) begin n_fail++; $display("FAIL single_upd: got %h exp %h", upd, e); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b exp 1", busy); end
    next_cycle();
    #1;
    n_checks++; if (upd !== '0) begin n_fail++; $display("FAIL single_after: got %h exp 0", upd); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall: got %b exp 0", busy); end
  endtask

  task automatic test_round_robin();
    btb_update_t e;
    logic [1:0]  exp_r;
    logic [31:0] prev_pc, prev_tgt;
    prev_pc = '0; prev_tgt = '0;
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) begin
        valid  = 2'b11;
        pc[0]  = 32'h0000_0100 + 32'(k) * 32'd4;  tgt[0] = 32'h0000_A000 + 32'(k);
        pc[1]  = 32'h0000_0200 + 32'(k) * 32'd4;  tgt[1] = 32'h0000_B000 + 32'(k);
      end else begin
        valid = 2'b00;
      end
      #1;
      if (k < 4) begin
        exp_r = (k % 2 == 0) ? 2'b01 : 2'b10;
        n_checks++; if (ready !== exp_r) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b exp %b", k, ready, exp_r); end
      end
      e = (k == 0) ? btb_update_t'(0) : '{valid: 1'b1, pc: prev_pc, target_address: prev_tgt};
      n_checks++; if (upd !== e) begin n_fail++; $display("FAIL rr_upd[%0d]: got %h exp %h", k, upd, e); end
      prev_pc  = pc[k % 2];
      prev_tgt = tgt[k % 2];
      next_cycle();
    end
  endtask

  task automatic test_debug_hold();
    btb_update_t e;
    valid = 2'b01; pc[0] = 32'h40; tgt[0] = 32'h80; dbg = 1'b0;
    #1;
    n_checks++; if (ready !== 2'b01) begin n_fail++; $display("FAIL dbg_push_ready: got %b exp 01", ready); end
    next_cycle();
    dbg = 1'b1; tgt[0] = 32'hC0;
    #1;
    n_checks++; if (ready !== 2'b01) begin n_fail++; $display("FAIL dbg_discard_ready: got %b exp 01", ready); end
    n_checks++; if (upd !== '0) begin n_fail++; $display("FAIL dbg_stall: got %h exp 0", upd); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL dbg_busy: got %b exp 1", busy); end
    next_cycle();
    valid = 2'b00;
    #1;
    n_checks++; if (upd !== '0) begin n_fail++; $display("FAIL dbg_hold: got %h exp 0", upd); end
    next_cycle();
    dbg = 1'b0;
    #1;
    e = '{valid: 1'b1, pc: 32'h40, target_address: 32'h80};
    n_checks++; if (upd !== e) begin n_fail++; $display("FAIL dbg_resume: got %h exp %h", upd, e); end
    next_cycle();
    #1;
    n_checks++; if (upd !== '0) begin n_fail++; $display("FAIL dbg_drained: got %h exp 0", upd); end
`ifdef BTB_UPD_STATS_EN
    n_checks++; if (st_drop !== 16'd1) begin n_fail++; $display("FAIL stat_dropped: got %0d exp 1", st_drop); end
    n_checks++; if (st_coal !== 16'd0) begin n_fail++; $display("FAIL stat_coalesced: got %0d exp 0", st_coal); end
`endif
  endtask

  task automatic test_flush();
    btb_update_t e;
    valid = 2'b10; pc[1] = 32'h500; tgt[1] = 32'h600;
    #1;
    n_checks++; if (ready !== 2'b10) begin n_fail++; $display("FAIL fl_push_ready: got %b exp 10", ready); end
    next_cycle();
    valid = 2'b00; dbg = 1'b1;
    next_cycle();
    flush = 1'b1; valid = 2'b11;
    #1;
    n_checks++; if (ready !== 2'b00) begin n_fail++; $display("FAIL fl_ready0: got %b exp 00", ready); end
    n_checks++; if (upd !== '0) begin n_fail++; $display("FAIL fl_upd0: got %h exp 0", upd); end
    n_checks++; if (bflush !== 1'b0) begin n_fail++; $display("FAIL fl_pulse0: got %b exp 0", bflush); end
    next_cycle();
    flush = 1'b0; dbg = 1'b0;
    #1;
    n_checks++; if (bflush !== 1'b1) begin n_fail++; $display("FAIL fl_pulse1: got %b exp 1", bflush); end
    n_checks++; if (ready !== 2'b00) begin n_fail++; $display("FAIL fl_ready1: got %b exp 00", ready); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fl_busy1: got %b exp 1", busy); end
    n_checks++; if (upd !== '0) begin n_fail++; $display("FAIL fl_upd1: got %h exp 0", upd); end
    next_cycle();
    #1;
    n_checks++; if (bflush !== 1'b0) begin n_fail++; $display("FAIL fl_pulse2: got %b exp 0", bflush); end
    n_checks++; if (ready !== 2'b00) begin n_fail++; $display("FAIL fl_ready2: got %b exp 00", ready); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fl_busy2: got %b exp 1", busy); end
    next_cycle();
    valid = 2'b10; pc[1] = 32'h700; tgt[1] = 32'h800;
    #1;
    n_checks++; if (ready !== 2'b10) begin n_fail++; $display("FAIL fl_ready3: got %b exp 10", ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fl_busy3: got %b exp 0", busy); end
    n_checks++; if (upd !== '0) begin n_fail++; $display("FAIL fl_no_stale: got %h exp 0", upd); end
    next_cycle();
    valid = 2'b00;
    #1;
    e = '{valid: 1'b1, pc: 32'h700, target_address: 32'h800};
    n_checks++; if (upd !== e) begin n_fail++; $display("FAIL fl_resume: got %h exp %h", upd, e); end
`ifdef BTB_UPD_STATS_EN
    n_checks++; if (st_fl !== 16'd1) begin n_fail++; $display("FAIL stat_flushed: got %0d exp 1", st_fl); end
`endif
    next_cycle();
  endtask

  task automatic test_reset_mid();
    valid = 2'b01; pc[0] = 32'h900; tgt[0] = 32'hA00; dbg = 1'b0;
    next_cycle();
    valid = 2'b00; dbg = 1'b1;
    next_cycle();
    flush = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (ready !== 2'b00) begin n_fail++; $display("FAIL rst_mid_ready: got %b exp 00", ready); end
    n_checks++; if (upd !== '0) begin n_fail++; $display("FAIL rst_mid_upd: got %h exp 0", upd); end
    n_checks++; if (bflush !== 1'b0) begin n_fail++; $display("FAIL rst_mid_flush: got %b exp 0", bflush); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b exp 0", busy); end
    next_cycle();
    flush = 1'b0; dbg = 1'b0; rst_n = 1'b1;
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (upd !== '0) begin n_fail++; $display("FAIL rst_mid_stale[%0d]: got %h exp 0", k, upd); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle[%0d]: got %b exp 0", k, busy); end
      next_cycle();
    end
  endtask

  task automatic test_random();
    logic [31:0] m_pc[$];
    logic [31:0] m_tgt[$];
    int          hold, s_coal, s_drop, s_fl;
    bit          rr, fl_q, can, g, pop, hs, coal, exp_busy;
    logic [1:0]  exp_ready;
    btb_update_t exp_upd;
    do_reset();
    hold = 0; rr = 1'b0; fl_q = 1'b0; s_coal = 0; s_drop = 0; s_fl = 0;
    for (int c = 0; c < 800; c++) begin
      valid = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++) begin
        pc[p]  = 32'h10 * 32'($urandom_range(1, 3));
        tgt[p] = $urandom;
      end
      dbg   = ($urandom_range(0, 9) < 2);
      flush = ($urandom_range(0, 24) == 0);
      #1;
      can       = (hold == 0) && !flush && (m_pc.size() < DEPTH);
      g         = (valid == 2'b11) ? rr : (valid == 2'b10);
      exp_ready = !can ? 2'b00 : (g ? 2'b10 : 2'b01);
      pop       = (m_pc.size() > 0) && (hold == 0) && !dbg && !flush;
      exp_upd   = pop ? '{valid: 1'b1, pc: m_pc[0], target_address: m_tgt[0]} : btb_update_t'(0);
      exp_busy  = (m_pc.size() > 0) || (hold > 0);
      n_checks++; if (ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b exp %b", c, ready, exp_ready); end
      n_checks++; if (upd !== exp_upd) begin n_fail++; $display("FAIL rnd_upd[%0d]: got %h exp %h", c, upd, exp_upd); end
      n_checks++; if (busy !== exp_busy) begin n_fail++; $display("FAIL rnd_busy[%0d]: got %b exp %b", c, busy, exp_busy); end
      n_checks++; if (bflush !== fl_q) begin n_fail++; $display("FAIL rnd_flush[%0d]: got %b exp %b", c, bflush, fl_q); end
`ifdef BTB_UPD_STATS_EN
      n_checks++; if (st_coal !== 16'(s_coal)) begin n_fail++; $display("FAIL rnd_stat_coal[%0d]: got %0d exp %0d", c, st_coal, s_coal); end
      n_checks++; if (st_drop !== 16'(s_drop)) begin n_fail++; $display("FAIL rnd_stat_drop[%0d]: got %0d exp %0d", c, st_drop, s_drop); end
      n_checks++; if (st_fl !== 16'(s_fl)) begin n_fail++; $display("FAIL rnd_stat_fl[%0d]: got %0d exp %0d", c, st_fl, s_fl); end
`endif
      hs = can && valid[g];
      if (flush) begin
        s_fl += m_pc.size();
        m_pc.delete();
        m_tgt.delete();
        hold = FLUSH_CYCLES;
      end else begin
        if (hold > 0) hold--;
        coal = hs && !dbg && (m_pc.size() > 0) && (pc[g] == m_pc[m_pc.size()-1])
               && !(pop && m_pc.size() == 1);
        if (pop) begin
          void'(m_pc.pop_front());
          void'(m_tgt.pop_front());
        end
        if (hs && valid == 2'b11) rr = !rr;
        if (hs && dbg) begin
          s_drop++;
        end else if (hs && coal) begin
          m_tgt[m_tgt.size()-1] = tgt[g];
          s_coal++;
        end else if (hs) begin
          m_pc.push_back(pc[g]);
          m_tgt.push_back(tgt[g]);
        end
      end
      fl_q = flush;
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_round_robin();
    test_debug_hold();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
